// File: rtl/alu_seq.sv
// alu_seq: sequential ALU for the EX pipeline stage.
//   Executes the 4-bit ALUCtrl codes. Single-cycle codes produce a registered
//   result one edge after start; mul (1010) runs an iterative shift-add
//   multiplier for WIDTH cycles while busy_o holds the pipeline.
// Build option: define ALU_MUL_EN to build the multiplier. Without it, code
//   1010 is answered as an illegal code in one cycle and busy_o is tied low.
//
// Handshake: start_i (with ctrl_i/src1_i/src2_i/shamt_i) is sampled on a
//   rising edge only while busy_o=0. Every accepted operation produces exactly
//   one done_o pulse; result_o and the flags are valid from that cycle and are
//   held until the next done_o. start_i in the done_o cycle is accepted, so
//   operations may be issued back to back. start_i while busy_o=1 is ignored.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int SHW    = 5,
    parameter int LUI_SH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             illegal_o,
    output logic             dbg_state_o
);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SRLV = 4'b0011;
    localparam logic [3:0] CTRL_SRL  = 4'b0100;
    localparam logic [3:0] CTRL_LUI  = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_ORI  = 4'b1000;
    localparam logic [3:0] CTRL_BNE  = 4'b1001;
    localparam logic [3:0] CTRL_MUL  = 4'b1010;
    localparam logic [3:0] CTRL_JR   = 4'b1011;

    localparam int MSB = WIDTH - 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state_q;

    // Multiplier interface into the output stage
    logic             mul_launch;   // mul accepted on this edge
    logic             mul_fire;     // last multiplier step happens on this edge
    logic [WIDTH-1:0] mul_res;      // accumulator value after the last step

    // Single-cycle datapath
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] diff_w;
    logic             slt_w;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_ovf;
    logic             alu_ill;

    // Registered outputs
    logic             done_q,   done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;
    logic             ill_q,    ill_d;

    assign sum_w  = src1_i + src2_i;
    assign diff_w = src1_i - src2_i;
    assign slt_w  = $signed(src1_i) < $signed(src2_i);

    // Signed overflow: operands that agree in sign (add) or differ (sub)
    // must not produce a result whose sign differs from src1.
    assign add_ovf = (src1_i[MSB] == src2_i[MSB]) && (sum_w[MSB]  != src1_i[MSB]);
    assign sub_ovf = (src1_i[MSB] != src2_i[MSB]) && (diff_w[MSB] != src1_i[MSB]);

    // Decode of all single-cycle codes into result and flags
    always_comb begin
        alu_res  = '0;
        alu_zero = 1'b0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        case (ctrl_i)
            CTRL_AND:  alu_res = src1_i & src2_i;
            CTRL_OR:   alu_res = src1_i | src2_i;
            CTRL_ADD: begin
                alu_res = sum_w;
                alu_ovf = add_ovf;
            end
            CTRL_SUB: begin
                alu_res = diff_w;
                alu_ovf = sub_ovf;
            end
            CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_w};
            CTRL_SRL:  alu_res = src2_i >> shamt_i;
            CTRL_SRLV: alu_res = src2_i >> src1_i[SHW-1:0];
            CTRL_LUI:  alu_res = src2_i << LUI_SH;
            CTRL_ORI:  alu_res = src1_i | {{(WIDTH-16){1'b0}}, src2_i[15:0]};
            CTRL_BNE:  alu_res = diff_w;
            CTRL_JR:   alu_res = src1_i;
            default:   alu_ill = 1'b1;
        endcase
        case (ctrl_i)
            // bne inverts the sense so the branch unit always takes on zero_o=1
            CTRL_BNE: alu_zero = (alu_res != '0);
            CTRL_JR:  alu_zero = 1'b0;
            default:  alu_zero = !alu_ill && (alu_res == '0);
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t           state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q,  mplr_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;

    assign mul_launch = (state_q == S_IDLE) && start_i && (ctrl_i == CTRL_MUL);
    assign mul_res    = acc_q + (mplr_q[0] ? mcand_q : '0);

    // FSM next state and shift-add step; carries past bit WIDTH-1 drop naturally
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        mul_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mul_launch) begin
                    state_d = S_MUL;
                    acc_d   = '0;
                    mcand_d = src1_i;
                    mplr_d  = src2_i;
                    cnt_d   = '0;
                end
            end
            S_MUL: begin
                acc_d   = mul_res;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_IDLE;
                    mul_fire = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and multiplier registers; reset aborts any multiply in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    // No multiplier: the FSM never leaves IDLE and 1010 decodes as illegal
    assign state_q    = S_IDLE;
    assign mul_launch = 1'b0;
    assign mul_fire   = 1'b0;
    assign mul_res    = '0;
`endif

    assign busy_o      = (state_q == S_MUL);
    assign dbg_state_o = state_q;

    // Output stage: load on a finishing multiply or an accepted single-cycle op, else hold
    always_comb begin
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        if (mul_fire) begin
            done_d   = 1'b1;
            result_d = mul_res;
            zero_d   = (mul_res == '0);
            ovf_d    = 1'b0;
            ill_d    = 1'b0;
        end else if (start_i && !busy_o && !mul_launch) begin
            done_d   = 1'b1;
            result_d = alu_res;
            zero_d   = alu_zero;
            ovf_d    = alu_ovf;
            ill_d    = alu_ill;
        end
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign done_o     = done_q;
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign illegal_o  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a cycle-level reference model.
module tb_alu_seq;

    localparam int W = 32;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SRLV = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_LUI  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_ORI  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_JR   = 4'b1011;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic         clk_i;
    logic         rst_i;
    logic         start_i;
    logic [3:0]   ctrl_i;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic [4:0]   shamt_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         overflow_o;
    logic         illegal_o;
    logic         dbg_state_o;

    int n_checks = 0;
    int n_err    = 0;

    alu_seq #(.WIDTH(W), .SHW(5), .LUI_SH(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .ctrl_i      (ctrl_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .shamt_i     (shamt_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .overflow_o  (overflow_o),
        .illegal_o   (illegal_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one single-cycle code, from the code table
    function automatic void ref_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [4:0] sh, output logic [W-1:0] r, output logic z,
                                   output logic o, output logic il);
        longint sa, sb, s;
        logic [W-1:0] imm;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        imm = {16'h0000, b[15:0]};
        r = '0; z = 1'b0; o = 1'b0; il = 1'b0;
        case (c)
            OP_ADD:  begin s = sa + sb; r = a + b; o = (s > SMAX) || (s < SMIN); z = (r == 0); end
            OP_SUB:  begin s = sa - sb; r = a - b; o = (s > SMAX) || (s < SMIN); z = (r == 0); end
            OP_AND:  begin r = a & b; z = (r == 0); end
            OP_OR:   begin r = a | b; z = (r == 0); end
            OP_SLT:  begin r = (sa < sb) ? 1 : 0; z = (r == 0); end
            OP_SRL:  begin r = b >> sh; z = (r == 0); end
            OP_SRLV: begin r = b >> a[4:0]; z = (r == 0); end
            OP_LUI:  begin r = b * 65536; z = (r == 0); end
            OP_ORI:  begin r = a | imm; z = (r == 0); end
            OP_BNE:  begin r = a - b; z = (r != 0); end
            OP_JR:   begin r = a; z = 1'b0; end
            default: begin r = '0; z = 1'b0; il = 1'b1; end
        endcase
    endfunction

    // ---------------- model + scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           m_left    = 0;
    logic [W-1:0] m_prod    = '0;
    logic         exp_done  = 1'b0;
    logic         exp_busy  = 1'b0;
    logic [W-1:0] hold_res  = '0;
    logic         hold_zero = 1'b0;
    logic         hold_ovf  = 1'b0;
    logic         hold_ill  = 1'b0;
    logic         nxt_zero  = 1'b0;
    logic         nxt_ovf   = 1'b0;
    logic         nxt_ill   = 1'b0;

    // Check outputs on every falling edge, then predict the coming rising edge
    always @(negedge clk_i) begin
        logic [W-1:0] r;
        logic         z, o, il;
        if (!rst_i) begin
            check("rst_busy",   W'(busy_o),     '0);
            check("rst_done",   W'(done_o),     '0);
            check("rst_result", result_o,       '0);
            check("rst_zero",   W'(zero_o),     '0);
            check("rst_ovf",    W'(overflow_o), '0);
            check("rst_ill",    W'(illegal_o),  '0);
            m_left = 0; exp_done = 1'b0; exp_busy = 1'b0;
            hold_res = '0; hold_zero = 1'b0; hold_ovf = 1'b0; hold_ill = 1'b0;
            exp_q.delete();
        end else begin
            check("busy",  W'(busy_o),      W'(exp_busy));
            check("state", W'(dbg_state_o), W'(exp_busy));
            check("done",  W'(done_o),      W'(exp_done));
            if (exp_done) begin
                check("sb_depth", W'(exp_q.size()), W'(1));
                if (exp_q.size() > 0) hold_res = exp_q.pop_front();
                hold_zero = nxt_zero; hold_ovf = nxt_ovf; hold_ill = nxt_ill;
            end
            check("result", result_o,       hold_res);
            check("zero",   W'(zero_o),     W'(hold_zero));
            check("ovf",    W'(overflow_o), W'(hold_ovf));
            check("ill",    W'(illegal_o),  W'(hold_ill));

            exp_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    exp_done = 1'b1;
                    exp_q.push_back(m_prod);
                    nxt_zero = (m_prod == 0); nxt_ovf = 1'b0; nxt_ill = 1'b0;
                end
            end else if (start_i) begin
                if (MUL_EN && ctrl_i == OP_MUL) begin
                    m_left = W;
                    m_prod = src1_i * src2_i;
                end else begin
                    ref_op(ctrl_i, src1_i, src2_i, shamt_i, r, z, o, il);
                    exp_done = 1'b1;
                    exp_q.push_back(r);
                    nxt_zero = z; nxt_ovf = o; nxt_ill = il;
                end
            end
            exp_busy = (m_left > 0);
        end
    end

    // ---------------- driver ----------------
    // Issue one operation (called just after a rising edge), wait for done_o,
    // and compare against hand-computed literals.
    task automatic run_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] er,
                          input logic ez, input logic eo, input logic ei, input int elat);
        int lat;
        bit got;
        ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk_i);
            if (done_o) got = 1'b1;
            else lat++;
        end
        check({name, "_got_done"}, W'(got),        W'(1));
        check({name, "_latency"},  W'(lat),        W'(elat));
        check({name, "_result"},   result_o,       er);
        check({name, "_zero"},     W'(zero_o),     W'(ez));
        check({name, "_ovf"},      W'(overflow_o), W'(eo));
        check({name, "_ill"},      W'(illegal_o),  W'(ei));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n_done, busy_n, lat;
        start_i = 1'b0; ctrl_i = '0; src1_i = '0; src2_i = '0; shamt_i = '0;
        rst_i = 1'b1;
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_busy",   W'(busy_o), '0);
        check("reset_done",   W'(done_o), '0);
        check("reset_result", result_o,   '0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // name           code     src1          src2          sh     result        z     o     i     lat
        run_op("add_ovf",  OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1, 1'b0, 1);
        run_op("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        run_op("sub_eq",   OP_SUB,  32'd5,        32'd5,        5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        run_op("sub_ovf",  OP_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1);
        run_op("bne_eq",   OP_BNE,  32'd5,        32'd5,        5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1);
        run_op("bne_ne",   OP_BNE,  32'd5,        32'd6,        5'd0,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1);
        run_op("slt_t",    OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        run_op("slt_f",    OP_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        run_op("srl_31",   OP_SRL,  32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        run_op("srlv_4",   OP_SRLV, 32'h00000004, 32'h000000F0, 5'd0,  32'h0000000F, 1'b0, 1'b0, 1'b0, 1);
        run_op("lui",      OP_LUI,  32'h00000000, 32'h00001234, 5'd0,  32'h12340000, 1'b0, 1'b0, 1'b0, 1);
        run_op("and",      OP_AND,  32'h0000F0F0, 32'h00000FF0, 5'd0,  32'h000000F0, 1'b0, 1'b0, 1'b0, 1);
        run_op("or",       OP_OR,   32'h0000F000, 32'h0000000F, 5'd0,  32'h0000F00F, 1'b0, 1'b0, 1'b0, 1);
        run_op("ori",      OP_ORI,  32'hFFFF0000, 32'hABCD1234, 5'd0,  32'hFFFF1234, 1'b0, 1'b0, 1'b0, 1);
        run_op("jr",       OP_JR,   32'h0000DEAD, 32'h00000001, 5'd0,  32'h0000DEAD, 1'b0, 1'b0, 1'b0, 1);
        run_op("jr_zero",  OP_JR,   32'h00000000, 32'h00000000, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1);
        run_op("illegal",  OP_BAD,  32'h12345678, 32'h9ABCDEF0, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1, 1);
        run_op("mul_small", OP_MUL, 32'd6, 32'd7, 5'd0, MUL_EN ? 32'd42 : 32'd0, 1'b0, 1'b0, !MUL_EN,
               MUL_EN ? 33 : 1);

        // Back-to-back issue: the second start is presented in the first done cycle
        ctrl_i = OP_ADD; src1_i = 32'd1; src2_i = 32'd2; start_i = 1'b1;
        @(posedge clk_i);
        #1 ctrl_i = OP_SUB; src1_i = 32'd10; src2_i = 32'd3;
        @(negedge clk_i);
        check("b2b_done1",   W'(done_o), W'(1));
        check("b2b_result1", result_o,   32'd3);
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        check("b2b_done2",   W'(done_o), W'(1));
        check("b2b_result2", result_o,   32'd7);
        @(posedge clk_i);
        #1;

        // Long multiply with stray start pulses while busy
        ctrl_i = OP_MUL; src1_i = 32'hFFFFFFFF; src2_i = 32'd3; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
`ifdef ALU_MUL_EN
        ctrl_i = OP_ADD; src1_i = 32'd1; src2_i = 32'd1;
`endif
        n_done = 0; busy_n = 0; lat = 0;
        for (int i = 1; i <= 40; i++) begin
`ifdef ALU_MUL_EN
            if (i == 5 || i == 12) start_i = 1'b1;
`endif
            @(negedge clk_i);
            if (busy_o) busy_n++;
            if (done_o) begin
                n_done++;
                if (lat == 0) lat = i;
            end
            @(posedge clk_i);
            #1 start_i = 1'b0;
        end
        check("mul_done_count", W'(n_done),   W'(1));
        check("mul_latency",    W'(lat),      W'(MUL_EN ? 33 : 1));
        check("mul_busy_cycles", W'(busy_n),  W'(MUL_EN ? 32 : 0));
        check("mul_result",     result_o,     MUL_EN ? 32'hFFFFFFFD : 32'h0);
        check("mul_ill",        W'(illegal_o), W'(!MUL_EN));

        // Reset during the tenth multiply cycle, then a fresh add
        ctrl_i = OP_MUL; src1_i = 32'hFFFFFFFF; src2_i = 32'hFFFFFFFF; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_busy",   W'(busy_o),    '0);
        check("midrst_done",   W'(done_o),    '0);
        check("midrst_result", result_o,      '0);
        check("midrst_ill",    W'(illegal_o), '0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        run_op("add_after_rst", OP_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0, 1);

        repeat (3) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
